// File: rtl/rx_pkg.sv
// rx_pkg: shared definitions for the serial receive path.
// Holds the word-alignment FSM state type and a helper that turns the
// log2 stage count into a word width.
package rx_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    MARKER,
    LOCKED
  } deser_state_t;

  // Word width for a given log2 stage count.
  function automatic int word_w(input int stages);
    return 1 << stages;
  endfunction

endpackage

// File: rtl/deser_align.sv
// deser_align: single-clock serial-to-parallel receiver with word alignment.
// Bits arrive LSB first, one per clock.  Alignment is found from the TX
// framing: at least MIN_IDLE zero bits, then one all-ones marker word.  Once
// locked, every W bits produce one parallel word with a one-cycle strobe.
//
// Ports:
//   clk        sampling clock, din captured on posedge
//   rstb       asynchronous active-low reset
//   din        serial data bit (first bit received = word bit 0)
//   realign    synchronous request to drop lock and restart the search
//   dout       last completed word (holds between strobes)
//   dout_valid one-cycle strobe when dout updates
//   locked     high while the receiver is word-aligned
//   align_err  sticky flag: a marker started but was not all ones
module deser_align
  import rx_pkg::*;
#(
  parameter int STAGES   = 5,
  parameter int MIN_IDLE = 2 ** STAGES
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   din,
  input  logic                   realign,
  output logic [2**STAGES-1:0]   dout,
  output logic                   dout_valid,
  output logic                   locked,
  output logic                   align_err
);

  localparam int W  = word_w(STAGES);
  localparam int ZW = $clog2(MIN_IDLE + 1);

  localparam logic [ZW-1:0]     MIN_Z   = ZW'(MIN_IDLE);
  localparam logic [STAGES-1:0] CNT_ONE = STAGES'(1);

  deser_state_t      state_q, state_d;
  logic [STAGES-1:0] cnt_q, cnt_d;
  logic [ZW-1:0]     zcnt_q, zcnt_d;
  // Only the W-1 most recent bits are kept: the word's last bit is taken
  // straight from din on the completing edge, and the oldest shifted-out
  // bit is never needed.
  logic [W-2:0]      sh_q, sh_d;
  logic [W-1:0]      shNext;
  logic [W-1:0]      dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  assign shNext = {din, sh_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    zcnt_d  = zcnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = err_q;

    // realign overrides everything; the bit sampled on this edge is dropped.
    if (realign) begin
      state_d = SEARCH;
      cnt_d   = '0;
      zcnt_d  = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (!din) begin
            if (zcnt_q < MIN_Z) begin
              zcnt_d = zcnt_q + 1'b1;
            end
          end else if (zcnt_q >= MIN_Z) begin
            // This one is marker bit 0, so the next bit is marker bit 1.
            state_d = MARKER;
            cnt_d   = CNT_ONE;
          end else begin
            zcnt_d = '0;
          end
        end

        MARKER: begin
          sh_d = shNext[W-1:1];
          if (!din) begin
            state_d = SEARCH;
            cnt_d   = '0;
            zcnt_d  = '0;
            err_d   = 1'b1;
          end else if (&cnt_q) begin
            state_d = LOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        LOCKED: begin
          sh_d  = shNext[W-1:1];
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) begin
            dout_d  = shNext;
            valid_d = 1'b1;
          end
        end

        default: begin
          state_d = SEARCH;
          cnt_d   = '0;
          zcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      zcnt_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zcnt_q  <= zcnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign locked     = (state_q == LOCKED);
  assign align_err  = err_q;

endmodule

// File: tb/tb_deser_align.sv
// tb_deser_align: self-checking bench for deser_align.
// Instance dutA uses a 4-bit word with MIN_IDLE=4 for the framing scenarios;
// instance dutB uses the 32-bit default for random streaming.
module tb_deser_align;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstb;
  logic        dinA, realignA, dinB, realignB;
  logic [3:0]  doutA;
  logic        validA, lockedA, errA;
  logic [31:0] doutB;
  logic        validB, lockedB, errB;

  int nCompared   = 0;
  int nMismatched = 0;

  deser_align #(.STAGES(2), .MIN_IDLE(4)) dutA (
    .clk        (clk),
    .rstb       (rstb),
    .din        (dinA),
    .realign    (realignA),
    .dout       (doutA),
    .dout_valid (validA),
    .locked     (lockedA),
    .align_err  (errA)
  );

  deser_align #(.STAGES(5), .MIN_IDLE(32)) dutB (
    .clk        (clk),
    .rstb       (rstb),
    .din        (dinB),
    .realign    (realignB),
    .dout       (doutB),
    .dout_valid (validB),
    .locked     (lockedB),
    .align_err  (errB)
  );

  // Drive one bit into dutA; outputs are then observed at the next negedge.
  task automatic stepA(input logic b, input logic ra);
    dinA     = b;
    realignA = ra;
    @(negedge clk);
  endtask

  task automatic stepB(input logic b);
    dinB = b;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rstb = 1'b1; dinA = 1'b0; dinB = 1'b0; realignA = 1'b0; realignB = 1'b0;
    #1 rstb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dinA = i[0];
      dinB = ~i[0];
      @(negedge clk);
      nCompared++;
      if ({doutA, validA, lockedA, errA} !== 7'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset_A cycle %0d got=%h want=0", i, {doutA, validA, lockedA, errA});
      end
      nCompared++;
      if ({doutB, validB, lockedB, errB} !== 35'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset_B cycle %0d got=%h want=0", i, {doutB, validB, lockedB, errB});
      end
    end
    dinA = 1'b0; dinB = 1'b0;
    rstb = 1'b1;
    @(negedge clk);
    nCompared++;
    if ({doutA, validA, lockedA, errA} !== 7'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_release got=%h want=0", {doutA, validA, lockedA, errA});
    end
  endtask

  task automatic test_lock_first_word;
    logic [3:0] d;
    int nValid;
    d = 4'b1101;
    nValid = 0;
    for (int i = 0; i < 8; i++) stepA(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) stepA(1'b1, 1'b0);
    nCompared++;
    if (lockedA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL lock_early got=%b want=0", lockedA);
    end
    stepA(1'b1, 1'b0);
    nCompared++;
    if (lockedA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL lock_marker got=%b want=1", lockedA);
    end
    for (int i = 0; i < 3; i++) begin
      stepA(d[i], 1'b0);
      if (validA === 1'b1) nValid++;
    end
    nCompared++;
    if (nValid != 0) begin
      nMismatched++;
      $display("[TB] FAIL first_word_early_valid got=%0d want=0", nValid);
    end
    stepA(d[3], 1'b0);
    nCompared++;
    if ({validA, doutA} !== {1'b1, 4'hD}) begin
      nMismatched++;
      $display("[TB] FAIL first_word got=%b/%h want=1/d", validA, doutA);
    end
    stepA(1'b0, 1'b0);
    nCompared++;
    if ({validA, doutA} !== {1'b0, 4'hD}) begin
      nMismatched++;
      $display("[TB] FAIL first_word_pulse got=%b/%h want=0/d", validA, doutA);
    end
  endtask

  task automatic test_short_idle;
    logic [9:0] seq;
    int anyValid, anyLocked;
    seq = 10'b0000111100;
    anyValid = 0; anyLocked = 0;
    stepA(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      stepA(seq[i], 1'b0);
      if (validA === 1'b1) anyValid++;
      if (lockedA === 1'b1) anyLocked++;
    end
    nCompared++;
    if ({anyValid != 0, anyLocked != 0, errA} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL short_idle valid=%0d locked=%0d err=%b want 0/0/0", anyValid, anyLocked, errA);
    end
  endtask

  task automatic test_broken_marker;
    logic [3:0] d;
    d = 4'b0010;
    stepA(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) stepA(1'b0, 1'b0);
    stepA(1'b1, 1'b0);
    stepA(1'b1, 1'b0);
    stepA(1'b0, 1'b0);
    nCompared++;
    if ({errA, lockedA} !== 2'b10) begin
      nMismatched++;
      $display("[TB] FAIL broken_marker err/locked got=%b%b want=10", errA, lockedA);
    end
    for (int i = 0; i < 4; i++) stepA(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) stepA(1'b1, 1'b0);
    nCompared++;
    if (lockedA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL relock_after_err got=%b want=1", lockedA);
    end
    for (int i = 0; i < 4; i++) stepA(d[i], 1'b0);
    nCompared++;
    if ({validA, doutA, errA} !== {1'b1, 4'h2, 1'b1}) begin
      nMismatched++;
      $display("[TB] FAIL broken_marker_word got=%b/%h/%b want=1/2/1", validA, doutA, errA);
    end
  endtask

  task automatic test_realign_mid_word;
    logic [7:0] seq;
    int anyValid, anyLocked;
    logic [3:0] w;
    anyValid = 0; anyLocked = 0;
    nCompared++;
    if (lockedA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL realign_precond locked got=%b want=1", lockedA);
    end
    stepA(1'b1, 1'b0);
    stepA(1'b1, 1'b0);
    stepA(1'b1, 1'b1);
    nCompared++;
    if ({lockedA, errA, validA} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL realign_clear got=%b%b%b want=000", lockedA, errA, validA);
    end
    // 1, three zeros, then a marker: idle too short to lock.
    seq = 8'b11110001;
    for (int i = 0; i < 8; i++) begin
      stepA(seq[i], 1'b0);
      if (validA === 1'b1) anyValid++;
      if (lockedA === 1'b1) anyLocked++;
    end
    // realign held high keeps the zero count at zero.
    for (int i = 0; i < 5; i++) begin
      stepA(1'b0, 1'b1);
      if (lockedA === 1'b1) anyLocked++;
    end
    seq = 8'b11110000;
    for (int i = 1; i < 8; i++) begin
      stepA(seq[i], 1'b0);
      if (validA === 1'b1) anyValid++;
      if (lockedA === 1'b1) anyLocked++;
    end
    nCompared++;
    if ({anyValid != 0, anyLocked != 0} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL realign_no_relock valid=%0d locked=%0d want 0/0", anyValid, anyLocked);
    end
    for (int i = 0; i < 8; i++) stepA(seq[i], 1'b0);
    nCompared++;
    if (lockedA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL realign_relock got=%b want=1", lockedA);
    end
    w = 4'($urandom);
    for (int i = 0; i < 4; i++) stepA(w[i], 1'b0);
    nCompared++;
    if ({validA, doutA} !== {1'b1, w}) begin
      nMismatched++;
      $display("[TB] FAIL realign_word got=%b/%h want=1/%h", validA, doutA, w);
    end
  endtask

  // Random idle lengths: lock happens only if the idle run reaches 4 zeros.
  task automatic test_random_idle;
    int idle;
    logic [3:0] w;
    logic expLock;
    int anyValid;
    for (int t = 0; t < 8; t++) begin
      stepA(1'b0, 1'b1);
      idle = int'($urandom_range(0, 9));
      expLock = (idle >= 4);
      w = 4'($urandom);
      anyValid = 0;
      for (int i = 0; i < idle; i++) stepA(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) stepA(1'b1, 1'b0);
      nCompared++;
      if (lockedA !== expLock) begin
        nMismatched++;
        $display("[TB] FAIL random_idle_lock idle=%0d got=%b want=%b", idle, lockedA, expLock);
      end
      for (int i = 0; i < 4; i++) begin
        stepA(w[i], 1'b0);
        if (i < 3 && validA === 1'b1) anyValid++;
      end
      nCompared++;
      if (expLock && ({validA, doutA} !== {1'b1, w} || anyValid != 0)) begin
        nMismatched++;
        $display("[TB] FAIL random_idle_word got=%b/%h want=1/%h", validA, doutA, w);
      end else if (!expLock && (validA !== 1'b0 || anyValid != 0)) begin
        nMismatched++;
        $display("[TB] FAIL random_idle_nolock_valid got=%b want=0", validA);
      end
    end
  endtask

  task automatic test_streaming;
    logic [31:0] sent[$];
    logic [31:0] w, expWord;
    int cycle, lastValid, nPulses;
    cycle = 0; lastValid = -1; nPulses = 0;
    for (int i = 0; i < 40; i++) stepB(1'b0);
    for (int i = 0; i < 31; i++) stepB(1'b1);
    nCompared++;
    if (lockedB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL stream_lock_early got=%b want=0", lockedB);
    end
    stepB(1'b1);
    nCompared++;
    if (lockedB !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL stream_lock got=%b want=1", lockedB);
    end
    for (int k = 0; k < 16; k++) begin
      w = $urandom;
      sent.push_back(w);
      for (int i = 0; i < 32; i++) begin
        stepB(w[i]);
        cycle++;
        nCompared++;
        if (validB !== (i == 31)) begin
          nMismatched++;
          $display("[TB] FAIL stream_valid word %0d bit %0d got=%b want=%b", k, i, validB, (i == 31));
        end
        if (validB === 1'b1) begin
          nPulses++;
          if (lastValid >= 0) begin
            nCompared++;
            if (cycle - lastValid != 32) begin
              nMismatched++;
              $display("[TB] FAIL stream_spacing got=%0d want=32", cycle - lastValid);
            end
          end
          lastValid = cycle;
          expWord = (sent.size() > 0) ? sent.pop_front() : 32'hx;
          nCompared++;
          if (doutB !== expWord) begin
            nMismatched++;
            $display("[TB] FAIL stream_word %0d got=%h want=%h", k, doutB, expWord);
          end
        end
      end
    end
    nCompared++;
    if (nPulses != 16 || errB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL stream_pulses got=%0d err=%b want=16 err=0", nPulses, errB);
    end
  endtask

  initial begin
    test_reset();
    test_lock_first_word();
    test_short_idle();
    test_broken_marker();
    test_realign_mid_word();
    test_random_idle();
    test_streaming();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
